// File: rtl/mul_writeback.sv
// Writeback stage after the 64x64 multiplier: captures a 128-bit product and
// writes the selected half/halves through an arbitrated register-file port.
module mul_writeback #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [2*XLEN-1:0] prod,
    input  logic [1:0]        op,
    input  logic [AW-1:0]     dest_lo,
    input  logic [AW-1:0]     dest_hi,
    input  logic [TAGW-1:0]   tag,
    output logic              rf_we,
    input  logic              rf_gnt,
    output logic [AW-1:0]     rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              done,
    output logic [TAGW-1:0]   done_tag,
    output logic              done_err
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;

    localparam logic [1:0] OP_LO   = 2'b00;
    localparam logic [1:0] OP_HI   = 2'b01;
    localparam logic [1:0] OP_BOTH = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    state_t            state_q, state_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [1:0]        op_q, op_d;
    logic [AW-1:0]     dest_lo_q, dest_lo_d;
    logic [AW-1:0]     dest_hi_q, dest_hi_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic              ready_q, ready_d;
    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              done_q, done_d;
    logic [TAGW-1:0]   done_tag_q, done_tag_d;
    logic              done_err_q, done_err_d;
    logic              accept;

    // ready is kept as a flop so it reads 0 throughout reset and rises on
    // the first edge after release, while still equal to (state == IDLE).
    assign accept = prod_valid && ready_q;

    always_comb begin
        state_d    = state_q;
        prod_d     = prod_q;
        op_d       = op_q;
        dest_lo_d  = dest_lo_q;
        dest_hi_d  = dest_hi_q;
        tag_d      = tag_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        done_tag_d = done_tag_q;
        done_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    prod_d    = prod;
                    op_d      = op;
                    dest_lo_d = dest_lo;
                    dest_hi_d = dest_hi;
                    tag_d     = tag;
                    // Writes to x0 are skipped outright.
                    unique case (op)
                        OP_LO:   state_d = (dest_lo != '0) ? WR_LO : DONE;
                        OP_HI:   state_d = (dest_hi != '0) ? WR_HI : DONE;
                        OP_BOTH: state_d = (dest_lo != '0) ? WR_LO :
                                           (dest_hi != '0) ? WR_HI : DONE;
                        default: state_d = DONE;
                    endcase
                end
            end
            WR_LO: begin
                if (rf_gnt) begin
                    state_d = (op_q == OP_BOTH && dest_hi_q != '0) ? WR_HI : DONE;
                end
            end
            WR_HI: begin
                if (rf_gnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: decode them from the state being entered.
        unique case (state_d)
            WR_LO: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = dest_lo_d;
                rf_wdata_d = prod_d[XLEN-1:0];
            end
            WR_HI: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = dest_hi_d;
                rf_wdata_d = prod_d[2*XLEN-1:XLEN];
            end
            DONE: begin
                done_d     = 1'b1;
                done_tag_d = tag_d;
                done_err_d = (op_d == OP_ILL);
            end
            default: begin
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prod_q     <= '0;
            op_q       <= '0;
            dest_lo_q  <= '0;
            dest_hi_q  <= '0;
            tag_q      <= '0;
            ready_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_q     <= prod_d;
            op_q       <= op_d;
            dest_lo_q  <= dest_lo_d;
            dest_hi_q  <= dest_hi_d;
            tag_q      <= tag_d;
            ready_q    <= ready_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            done_tag_q <= done_tag_d;
            done_err_q <= done_err_d;
        end
    end

    assign prod_ready = ready_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign done       = done_q;
    assign done_tag   = done_tag_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_mul_writeback.sv
// Bench for mul_writeback: directed latency table, hand sequences for stalls,
// queuing and mid-op reset, then random traffic against a transaction model.
module tb_mul_writeback;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         prod_valid;
    logic         prod_ready;
    logic [127:0] prod;
    logic [1:0]   op;
    logic [4:0]   dest_lo, dest_hi;
    logic [3:0]   tag;
    logic         rf_we, rf_gnt;
    logic [4:0]   rf_waddr;
    logic [63:0]  rf_wdata;
    logic         done;
    logic [3:0]   done_tag;
    logic         done_err;

    logic gnt_rand = 1'b0;
    logic gnt_man  = 1'b0;
    logic rnd_gnt  = 1'b1;
    assign rf_gnt = gnt_rand ? rnd_gnt : gnt_man;

    always #5 clk = ~clk;

    mul_writeback #(.XLEN(64), .AW(5), .TAGW(4)) dut (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .prod(prod), .op(op), .dest_lo(dest_lo), .dest_hi(dest_hi), .tag(tag),
        .rf_we(rf_we), .rf_gnt(rf_gnt), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .done_tag(done_tag), .done_err(done_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: each accepted product yields an ordered list
    // of register writes and one completion record.
    typedef struct { logic [4:0] a; logic [63:0] d; } wr_t;
    typedef struct { logic [3:0] t; logic e; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int n_acc = 0, n_wr = 0, n_done = 0;
    logic        prev_stall = 1'b0, prev_done = 1'b0;
    logic [4:0]  prev_addr;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_wr.delete();
            exp_dn.delete();
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_we",   128'(rf_we),    128'(1'b1));
                check("stall_addr", 128'(rf_waddr), 128'(prev_addr));
                check("stall_data", 128'(rf_wdata), 128'(prev_data));
            end
            if (rf_we && rf_gnt) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 128'(rf_waddr), 128'(0));
                    check("unexpected_write_cnt", 128'(1), 128'(0));
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 128'(rf_waddr), 128'(e.a));
                    check("wr_data", 128'(rf_wdata), 128'(e.d));
                end
            end
            if (done) begin
                n_done++;
                check("done_after_writes", 128'(exp_wr.size()), 128'(0));
                check("done_single_cycle", 128'(prev_done), 128'(0));
                if (exp_dn.size() == 0) begin
                    check("unexpected_done", 128'(1), 128'(0));
                end else begin
                    dn_t e;
                    e = exp_dn.pop_front();
                    check("done_tag", 128'(done_tag), 128'(e.t));
                    check("done_err", 128'(done_err), 128'(e.e));
                end
            end
            if (prod_valid && prod_ready) begin
                n_acc++;
                if ((op == 2'd0 || op == 2'd2) && dest_lo != 0) exp_wr.push_back('{dest_lo, prod[63:0]});
                if ((op == 2'd1 || op == 2'd2) && dest_hi != 0) exp_wr.push_back('{dest_hi, prod[127:64]});
                exp_dn.push_back('{tag, op == 2'd3});
            end
            prev_stall = rf_we && !rf_gnt;
            prev_addr  = rf_waddr;
            prev_data  = rf_wdata;
            prev_done  = done;
        end
    end

    always @(posedge clk) begin
        #1 rnd_gnt = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [127:0] p, input logic [1:0] o, input logic [4:0] dl,
                        input logic [4:0] dh, input logic [3:0] t, input bit keep);
        int w = 0;
        prod = p; op = o; dest_lo = dl; dest_hi = dh; tag = t; prod_valid = 1'b1;
        @(negedge clk);
        while (!prod_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!prod_ready) check("accept_timeout", 128'(prod_ready), 128'(1'b1));
        tick();
        if (!keep) prod_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_wr.size() != 0 || exp_dn.size() != 0 || !prod_ready) && w < 500) begin
            w++;
            @(negedge clk);
        end
        check("drain_writes", 128'(exp_wr.size()), 128'(0));
        check("drain_dones",  128'(exp_dn.size()), 128'(0));
        tick();
    endtask

    typedef struct {
        logic [127:0] p; logic [1:0] op; logic [4:0] dl; logic [4:0] dh; logic [3:0] tag;
        int lat; int nw; logic err;
    } vec_t;
    vec_t vt[10];

    localparam logic [127:0] P0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] P1 = 128'hDEADBEEF00000001_0000000CAFEF00D5;

    initial begin
        int a0, w0, d0, k;
        vt[0] = '{P0, 2'd2, 5'd5,  5'd6,  4'd3,  3, 2, 1'b0};
        vt[1] = '{P1, 2'd0, 5'd3,  5'd0,  4'd1,  2, 1, 1'b0};
        vt[2] = '{P1, 2'd1, 5'd0,  5'd4,  4'd2,  2, 1, 1'b0};
        vt[3] = '{P0, 2'd2, 5'd0,  5'd9,  4'd4,  2, 1, 1'b0};
        vt[4] = '{P0, 2'd0, 5'd0,  5'd9,  4'd5,  1, 0, 1'b0};
        vt[5] = '{P1, 2'd3, 5'd1,  5'd2,  4'd15, 1, 0, 1'b1};
        vt[6] = '{P1, 2'd2, 5'd8,  5'd8,  4'd6,  3, 2, 1'b0};
        vt[7] = '{P0, 2'd2, 5'd7,  5'd0,  4'd7,  2, 1, 1'b0};
        vt[8] = '{P0, 2'd1, 5'd3,  5'd0,  4'd8,  1, 0, 1'b0};
        vt[9] = '{P1, 2'd2, 5'd0,  5'd0,  4'd9,  1, 0, 1'b0};

        rst_n = 1'b0; prod_valid = 1'b0; prod = '0; op = '0; dest_lo = '0; dest_hi = '0; tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we",       128'(rf_we),      128'(0));
        check("rst_done",     128'(done),       128'(0));
        check("rst_err",      128'(done_err),   128'(0));
        check("rst_waddr",    128'(rf_waddr),   128'(0));
        check("rst_wdata",    128'(rf_wdata),   128'(0));
        check("rst_done_tag", 128'(done_tag),   128'(0));
        check("rst_ready",    128'(prod_ready), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("ready_after_release", 128'(prod_ready), 128'(1));
        tick();

        // BOTH, cycle by cycle.
        gnt_man = 1'b1;
        send(P0, 2'd2, 5'd5, 5'd6, 4'd3, 1'b0);
        @(negedge clk);
        check("both_c1_we",   128'(rf_we), 128'(1));
        check("both_c1_addr", 128'(rf_waddr), 128'(5));
        check("both_c1_data", 128'(rf_wdata), 128'(64'hFEDCBA9876543210));
        @(negedge clk);
        check("both_c2_we",   128'(rf_we), 128'(1));
        check("both_c2_addr", 128'(rf_waddr), 128'(6));
        check("both_c2_data", 128'(rf_wdata), 128'(64'h0123456789ABCDEF));
        @(negedge clk);
        check("both_c3_done", 128'(done), 128'(1));
        check("both_c3_tag",  128'(done_tag), 128'(3));
        check("both_c3_err",  128'(done_err), 128'(0));
        check("both_c3_we",   128'(rf_we), 128'(0));
        tick();

        // Latency table with grant tied high.
        for (int i = 0; i < 10; i++) begin
            w0 = n_wr;
            send(vt[i].p, vt[i].op, vt[i].dl, vt[i].dh, vt[i].tag, 1'b0);
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done && k < 20);
            check($sformatf("vec%0d_latency", i), 128'(k), 128'(vt[i].lat));
            check($sformatf("vec%0d_tag", i),     128'(done_tag), 128'(vt[i].tag));
            check($sformatf("vec%0d_err", i),     128'(done_err), 128'(vt[i].err));
            check($sformatf("vec%0d_writes", i),  128'(n_wr - w0), 128'(vt[i].nw));
            tick();
        end

        // HI write stalled three cycles.
        gnt_man = 1'b0;
        w0 = n_wr;
        send(P1, 2'd1, 5'd0, 5'd7, 4'd10, 1'b0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_hold_we",   128'(rf_we), 128'(1));
            check("stall_hold_addr", 128'(rf_waddr), 128'(7));
            check("stall_hold_data", 128'(rf_wdata), 128'(P1[127:64]));
        end
        tick();
        gnt_man = 1'b1;
        @(negedge clk);
        check("stall_grant_we", 128'(rf_we), 128'(1));
        tick();
        gnt_man = 1'b0;
        @(negedge clk);
        check("stall_done", 128'(done), 128'(1));
        check("stall_one_write", 128'(n_wr - w0), 128'(1));
        tick();

        // Three products queued with prod_valid held high.
        gnt_man = 1'b1;
        a0 = n_acc; w0 = n_wr;
        send(128'h11112222_33334444_55556666_77778888, 2'd0, 5'd10, 5'd11, 4'd1, 1'b1);
        send(128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000, 2'd1, 5'd12, 5'd13, 4'd2, 1'b1);
        send(128'h13579BDF_2468ACE0_0FEDCBA9_87654321, 2'd2, 5'd14, 5'd15, 4'd3, 1'b0);
        drain();
        check("queue_accepts", 128'(n_acc - a0), 128'(3));
        check("queue_writes",  128'(n_wr - w0), 128'(4));

        // Reset while the high write of a BOTH op is pending.
        d0 = n_done;
        send(P0, 2'd2, 5'd1, 5'd2, 4'd9, 1'b0);
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_wr_hi", 128'(rf_we), 128'(1));
        @(negedge clk);
        check("midrst_we",    128'(rf_we), 128'(0));
        check("midrst_done",  128'(done), 128'(0));
        check("midrst_ready", 128'(prod_ready), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_ready_after", 128'(prod_ready), 128'(1));
        repeat (3) @(negedge clk);
        check("midrst_no_done", 128'(n_done - d0), 128'(0));
        tick();

        // Random traffic with random grants.
        gnt_rand = 1'b1;
        a0 = n_acc; d0 = n_done;
        for (int i = 0; i < 60; i++) begin
            logic [127:0] rp;
            rp = {$urandom, $urandom, $urandom, $urandom};
            send(rp, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                prod_valid = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
            end
        end
        prod_valid = 1'b0;
        drain();
        check("rand_accepts", 128'(n_acc - a0), 128'(60));
        check("rand_dones",   128'(n_done - d0), 128'(60));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
